weight_kernel_buffer: RTL

- Downstream neighbour of the weight-RAM read-address generator.
- Holds the kernel weight RAM and consumes the generator's read address and read strobe, one RAM row per strobe.
- Assembles kernel_size rows into a complete kernel window and presents it to the convolution MAC array with a valid/ready handshake.
- Applies back-pressure to the address generator while a finished window has not been taken.

---
 rtl/cnn_weight_pkg.sv | 21 ++
 rtl/weight_row_ram.sv | 35 +++
 rtl/weight_kernel_buffer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cnn_weight_pkg.sv
// Shared definitions for the kernel weight buffer: default sizes, FSM encoding
// and the window bit-offset helper.
package cnn_weight_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int MAX_K_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    LAST = 2'd2,
    HOLD = 2'd3
  } wkb_state_e;

  // Bit offset of window element (row r, column c) in the flattened window.
  function automatic int kw_offset(input logic [2:0] r, input int c,
                                   input int max_k, input int data_w);
    return (int'(r) * max_k + c) * data_w;
  endfunction

endpackage

// File: rtl/weight_row_ram.sv
// Kernel weight RAM: DEPTH rows of ROW_W bits, synchronous write, read-first
// synchronous read with one cycle of latency. Out-of-range rows are inert.
module weight_row_ram
  import cnn_weight_pkg::*;
#(
  parameter int DEPTH = MAX_K_DEF,
  parameter int ROW_W = MAX_K_DEF * DATA_W_DEF
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [ROW_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [2:0]       rd_addr,
  output logic [ROW_W-1:0] rd_data
);

  localparam logic [2:0] DEPTH3 = 3'(DEPTH);

  logic [ROW_W-1:0] mem_r [DEPTH];
  logic [ROW_W-1:0] rd_data_r;

  // Storage array and registered read port; the read samples pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH3)) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_r <= (rd_addr < DEPTH3) ? mem_r[rd_addr] : '0;
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/weight_kernel_buffer.sv
// Collects k RAM rows into a k x k weight window and hands it to the MAC array
// over valid/ready. Optional address-sequence check: WEIGHT_SEQ_CHECK_EN.
module weight_kernel_buffer
  import cnn_weight_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_K  = MAX_K_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [2:0]                      wr_addr,
  input  logic [MAX_K*DATA_W-1:0]         wr_data,
  input  logic [2:0]                      kernel_size,
  input  logic [2:0]                      addr_RAM_weight,
  input  logic                            read_RAM_weight,
  output logic                            row_ready,
  output logic                            kernel_valid,
  input  logic                            kernel_ready,
  output logic [MAX_K*MAX_K*DATA_W-1:0]   kernel_data,
  output logic [2:0]                      kernel_rows,
  output logic                            cfg_err
);

  localparam int         ROW_W  = MAX_K * DATA_W;
  localparam int         WIN_W  = MAX_K * MAX_K * DATA_W;
  localparam logic [2:0] MAX_K3 = 3'(MAX_K);

  wkb_state_e       state_r;
  wkb_state_e       next_state_s;
  logic             row_ready_r;
  logic             row_ready_s;
  logic             kernel_valid_r;
  logic             kernel_valid_s;
  logic [2:0]       cnt_r;
  logic [2:0]       cnt_inc_s;
  logic [2:0]       k_eff_r;
  logic [2:0]       k_in_s;
  logic [2:0]       row_idx_r;
  logic             row_wr_r;
  logic             accept_s;
  logic             first_s;
  logic             ksize_ok_s;
  logic             seq_err_s;
  logic             cfg_err_r;
  logic [2:0]       kernel_rows_r;
  logic [WIN_W-1:0] kernel_data_r;
  logic [ROW_W-1:0] rd_data_s;

  weight_row_ram #(
    .DEPTH (MAX_K),
    .ROW_W (ROW_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (accept_s),
    .rd_addr (addr_RAM_weight),
    .rd_data (rd_data_s)
  );

  // Strobe acceptance, kernel-size qualification and sequence checking.
  always_comb begin
    accept_s   = read_RAM_weight & row_ready_r;
    first_s    = accept_s & (state_r == IDLE);
    ksize_ok_s = (kernel_size != 3'd0) && (kernel_size <= MAX_K3);
    k_in_s     = ksize_ok_s ? kernel_size : MAX_K3;
    cnt_inc_s  = cnt_r + 3'd1;
`ifdef WEIGHT_SEQ_CHECK_EN
    seq_err_s  = accept_s &&
                 (addr_RAM_weight != ((state_r == IDLE) ? 3'd0 : cnt_r));
`else
    seq_err_s  = 1'b0;
`endif
  end

  // FSM state register together with its registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      row_ready_r    <= 1'b1;
      kernel_valid_r <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      row_ready_r    <= row_ready_s;
      kernel_valid_r <= kernel_valid_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (k_in_s == 3'd1) ? LAST : FILL;
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL: begin
        if (accept_s && (cnt_inc_s == k_eff_r)) begin
          next_state_s = LAST;
        end else begin
          next_state_s = FILL;
        end
      end
      LAST: next_state_s = HOLD;
      HOLD: begin
        if (kernel_valid_r && kernel_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the registered copies line up with it.
  always_comb begin
    row_ready_s    = (next_state_s == IDLE) || (next_state_s == FILL);
    kernel_valid_s = (next_state_s == HOLD);
  end

  // Row counter, window assembly and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r         <= 3'd0;
      k_eff_r       <= 3'd0;
      row_idx_r     <= 3'd0;
      row_wr_r      <= 1'b0;
      kernel_rows_r <= 3'd0;
      kernel_data_r <= '0;
      cfg_err_r     <= 1'b0;
    end else begin
      row_wr_r  <= accept_s;
      row_idx_r <= (state_r == IDLE) ? 3'd0 : cnt_r;
      if (first_s) begin
        cnt_r         <= 3'd1;
        k_eff_r       <= k_in_s;
        kernel_rows_r <= k_in_s;
        kernel_data_r <= '0;
      end else if (accept_s) begin
        cnt_r <= cnt_inc_s;
      end
      // RAM data lands one cycle after its accept; unused columns are masked off.
      if (row_wr_r) begin
        for (int c = 0; c < MAX_K; c++) begin
          if (3'(c) < k_eff_r) begin
            kernel_data_r[kw_offset(row_idx_r, c, MAX_K, DATA_W) +: DATA_W] <=
              rd_data_s[c*DATA_W +: DATA_W];
          end else begin
            kernel_data_r[kw_offset(row_idx_r, c, MAX_K, DATA_W) +: DATA_W] <= '0;
          end
        end
      end
      if ((first_s && !ksize_ok_s) || seq_err_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  assign row_ready    = row_ready_r;
  assign kernel_valid = kernel_valid_r;
  assign kernel_data  = kernel_data_r;
  assign kernel_rows  = kernel_rows_r;
  assign cfg_err      = cfg_err_r;

endmodule
